// File: rtl/instr_sequencer.sv
// Sequencing front end for the 4-step datapath controller: instruction FIFO,
// instruction register, step counter T, watchdog and retired-instruction count.
module instr_sequencer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic [9:0]               instr_in,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     clr_in,
  output logic [9:0]               ir_out,
  output logic [1:0]               t_out,
  output logic                     step_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [CNT_W-1:0]         instr_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    T0_FETCH = 2'd0,
    T1_EXEC  = 2'd1,
    T2_EXEC  = 2'd2,
    T3_EXEC  = 2'd3
  } step_t;

  step_t             state_reg;
  logic [9:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       level_reg;
  logic [9:0]        ir_reg;
  logic              done_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  count_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic exec_step;

  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign empty = (level_reg == '0);

  // Readiness is just !full, so a pop in the same cycle never opens a slot early.
  assign instr_ready = !full;
  assign push        = instr_valid && !full && !flush;
  assign pop         = (state_reg == T0_FETCH) && en && !empty && !flush;
  assign exec_step   = (state_reg != T0_FETCH) && en && !flush;

  assign t_out       = state_reg;
  assign ir_out      = ir_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign instr_count = count_reg;
  assign fifo_level  = level_reg;
  assign busy        = (state_reg != T0_FETCH);
  assign step_valid  = (state_reg != T0_FETCH) || (en && !empty);

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= T0_FETCH;
      ir_reg    <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else if (flush) begin
      state_reg <= T0_FETCH;
      ir_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        T0_FETCH: begin
          if (pop) begin
            ir_reg    <= mem[rd_ptr_reg];
            state_reg <= T1_EXEC;
          end
        end
        T1_EXEC, T2_EXEC: begin
          if (exec_step) begin
            if (clr_in) begin
              state_reg <= T0_FETCH;
              done_reg  <= 1'b1;
              count_reg <= count_reg + CNT_W'(1);
            end else begin
              state_reg <= step_t'(state_reg + 2'd1);
            end
          end
        end
        default: begin
          // Step 3 without Clr is a hung instruction: abandon it and flag it.
          if (exec_step) begin
            state_reg <= T0_FETCH;
            if (clr_in) begin
              done_reg  <= 1'b1;
              count_reg <= count_reg + CNT_W'(1);
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
